rf_sequencer: RTL and testbench

RF_SEQUENCER -- requirements
Module: rf_sequencer

---
 rtl/rf_sequencer_pkg.sv | 28 ++
 rtl/seq_alu.sv | 45 ++++
 rtl/rf_sequencer.sv | 124 ++++++++++++
 tb/tb_rf_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_sequencer_pkg.sv
// Shared types for the register-file sequencer: FSM states, ALU op and
// B-operand shift encodings.
package rf_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOADA = 3'd1,
        S_LOADB = 3'd2,
        S_EXEC  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_CMP = 2'b01,
        OP_AND = 2'b10,
        OP_MVN = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL1 = 2'b01,
        SH_LSR1 = 2'b10,
        SH_ASR1 = 2'b11
    } shift_t;

endpackage

// File: rtl/seq_alu.sv
// Combinational B-operand shifter plus ALU for the sequencer.
// V is the signed-overflow flag of the subtraction A - Bsh.
module seq_alu
    import rf_sequencer_pkg::*;
#(
    parameter int unsigned DW = 16
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  op_t           op_i,
    input  shift_t        shift_i,
    output logic [DW-1:0] result_o,
    output logic          z_o,
    output logic          n_o,
    output logic          v_o
);

    logic [DW-1:0] bsh;

    // Shift B, then apply the selected operation and derive flags
    always_comb begin
        bsh = b_i;
        unique case (shift_i)
            SH_NONE: bsh = b_i;
            SH_LSL1: bsh = {b_i[DW-2:0], 1'b0};
            SH_LSR1: bsh = {1'b0, b_i[DW-1:1]};
            SH_ASR1: bsh = {b_i[DW-1], b_i[DW-1:1]};
            default: bsh = b_i;
        endcase

        result_o = '0;
        unique case (op_i)
            OP_ADD:  result_o = a_i + bsh;
            OP_CMP:  result_o = a_i - bsh;
            OP_AND:  result_o = a_i & bsh;
            OP_MVN:  result_o = ~bsh;
            default: result_o = '0;
        endcase

        z_o = (result_o == '0);
        n_o = result_o[DW-1];
        v_o = (a_i[DW-1] != bsh[DW-1]) && (result_o[DW-1] != a_i[DW-1]);
    end

endmodule

// File: rtl/rf_sequencer.sv
// Multi-cycle register-file sequencer: reads A (rn) and B (rm) from an
// external register file, runs seq_alu, writes C back to rd.
// Optional feature macro: STATUS_NV_EN enables the N and V status flags;
// without it only Z is tracked and status[2:1] stays 0.
module rf_sequencer
    import rf_sequencer_pkg::*;
#(
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [1:0]    shift,
    input  logic [2:0]    rn,
    input  logic [2:0]    rm,
    input  logic [2:0]    rd,
    input  logic [DW-1:0] data_out,
    output logic [2:0]    readnum,
    output logic [2:0]    writenum,
    output logic          write,
    output logic [DW-1:0] data_in,
    output logic [2:0]    status,
    output logic          busy,
    output logic          done
);

    state_t        state_q, state_d;
    op_t           op_q;
    shift_t        shift_q;
    logic [2:0]    rn_q, rm_q, rd_q;
    logic [DW-1:0] a_q, b_q, c_q;
    logic [2:0]    status_q;

    logic [DW-1:0] alu_result;
    logic          alu_z, alu_n, alu_v;
    logic [2:0]    status_calc;

    seq_alu #(.DW(DW)) u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .shift_i  (shift_q),
        .result_o (alu_result),
        .z_o      (alu_z),
        .n_o      (alu_n),
        .v_o      (alu_v)
    );

`ifdef STATUS_NV_EN
    assign status_calc = {alu_v, alu_n, alu_z};
`else
    logic unused_nv;
    assign unused_nv   = alu_v ^ alu_n;
    assign status_calc = {2'b00, alu_z};
`endif

    // State register; reset wins over everything in flight
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; MVN skips LOADA, CMP skips WRITE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = (op_t'(op) == OP_MVN) ? S_LOADB : S_LOADA;
            S_LOADA: state_d = S_LOADB;
            S_LOADB: state_d = S_EXEC;
            S_EXEC:  state_d = (op_q == OP_CMP) ? S_DONE : S_WRITE;
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Register-file control and handshake outputs decoded from state
    always_comb begin
        readnum  = 3'd0;
        write    = 1'b0;
        writenum = rd_q;
        data_in  = c_q;
        status   = status_q;
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        unique case (state_q)
            S_LOADA: readnum = rn_q;
            S_LOADB: readnum = rm_q;
            S_WRITE: write   = 1'b1;
            default: ;
        endcase
    end

    // Datapath: latch the request, capture operands, result and flags
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= OP_ADD;
            shift_q  <= SH_NONE;
            rn_q     <= 3'd0;
            rm_q     <= 3'd0;
            rd_q     <= 3'd0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_q <= 3'b000;
        end else begin
            if (state_q == S_IDLE && start) begin
                op_q    <= op_t'(op);
                shift_q <= shift_t'(shift);
                rn_q    <= rn;
                rm_q    <= rm;
                rd_q    <= rd;
            end
            if (state_q == S_LOADA) a_q <= data_out;
            if (state_q == S_LOADB) b_q <= data_out;
            if (state_q == S_EXEC) begin
                c_q <= alu_result;
                if (op_q == OP_CMP) status_q <= status_calc;
            end
        end
    end

endmodule

// File: tb/tb_rf_sequencer.sv
// Self-checking bench for rf_sequencer: a behavioural register file driven
// by the DUT, a write scoreboard, and directed operation steps.
module tb_rf_sequencer;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [1:0]  op, shift;
    logic [2:0]  rn, rm, rd;
    logic [15:0] data_out;
    logic [2:0]  readnum, writenum;
    logic        write;
    logic [15:0] data_in;
    logic [2:0]  status;
    logic        busy, done;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;

    typedef struct packed {
        logic [2:0]  wn;
        logic [15:0] d;
    } wr_t;
    wr_t exp_q[$];

    logic [15:0] rf [8];
    logic        pl_en = 1'b0;
    logic [2:0]  pl_idx = 3'd0;
    logic [15:0] pl_val = 16'd0;

    always #5 clk = ~clk;

    rf_sequencer #(.DW(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .shift    (shift),
        .rn       (rn),
        .rm       (rm),
        .rd       (rd),
        .data_out (data_out),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .data_in  (data_in),
        .status   (status),
        .busy     (busy),
        .done     (done)
    );

    // Register file: combinational read, written by DUT or by preload
    assign data_out = rf[readnum];
    always @(posedge clk) begin
        if (write)  rf[writenum] <= data_in;
        if (pl_en)  rf[pl_idx]   <= pl_val;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every observed write pops one expected entry
    always @(negedge clk) begin
        if (write === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {13'd0, writenum, data_in}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_num", {29'd0, writenum}, {29'd0, e.wn});
                check("wr_data", {16'd0, data_in}, {16'd0, e.d});
            end
        end
    end

    task automatic preload(input logic [2:0] idx, input logic [15:0] val);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Issue one op; lat counts edges from the accepting edge to done high
    task automatic run_op(input logic [1:0] o, input logic [1:0] s,
                          input logic [2:0] n_, input logic [2:0] m_, input logic [2:0] d_,
                          output int lat, output int wr, output logic [2:0] rn_first);
        int w0;
        w0 = wr_cnt;
        start = 1'b1; op = o; shift = s; rn = n_; rm = m_; rd = d_;
        lat = 0;
        rn_first = 3'd0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (lat == 1) rn_first = readnum;
        end while (done !== 1'b1 && lat < 20);
        wr = wr_cnt - w0;
        $display("op=%0d shift=%0d rn=%0d rm=%0d rd=%0d latency=%0d writes=%0d status=%b",
                 o, s, n_, m_, d_, lat, wr, status);
    endtask

    initial begin
        int lat, wr;
        logic [2:0] rf1;
        logic [2:0] exp_cmp_status;

        reset = 1'b1; start = 1'b0; op = 2'b00; shift = 2'b00;
        rn = 3'd0; rm = 3'd0; rd = 3'd0;
        for (int i = 0; i < 8; i++) begin
            pl_en = 1'b1; pl_idx = 3'(i); pl_val = 16'h0;
            @(posedge clk); #1;
        end
        pl_en = 1'b0;

        // Reset state
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_write", {31'd0, write}, 32'd0);
        check("rst_readnum", {29'd0, readnum}, 32'd0);
        check("rst_writenum", {29'd0, writenum}, 32'd0);
        check("rst_data_in", {16'd0, data_in}, 32'd0);
        check("rst_status", {29'd0, status}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // ADD R2 = R0 + R1 = 5 + 3
        preload(3'd0, 16'h0005);
        preload(3'd1, 16'h0003);
        exp_q.push_back('{wn: 3'd2, d: 16'h0008});
        run_op(2'b00, 2'b00, 3'd0, 3'd1, 3'd2, lat, wr, rf1);
        check("add_latency", lat, 5);
        check("add_writes", wr, 1);
        check("add_rf_first", {29'd0, rf1}, 32'd0);
        @(posedge clk); #1;
        check("add_r2", {16'd0, rf[2]}, 32'h0008);
        check("add_idle", {31'd0, busy}, 32'd0);

        // CMP 0x8000 - 0x0001: signed overflow
        preload(3'd0, 16'h8000);
        preload(3'd1, 16'h0001);
`ifdef STATUS_NV_EN
        exp_cmp_status = 3'b100;
`else
        exp_cmp_status = 3'b000;
`endif
        run_op(2'b01, 2'b00, 3'd0, 3'd1, 3'd5, lat, wr, rf1);
        check("cmp_latency", lat, 4);
        check("cmp_writes", wr, 0);
        check("cmp_status", {29'd0, status}, {29'd0, exp_cmp_status});

        // CMP equal operands sets Z
        preload(3'd0, 16'h0001);
        run_op(2'b01, 2'b00, 3'd0, 3'd1, 3'd5, lat, wr, rf1);
        check("cmpz_status", {29'd0, status}, 32'b001);

        // MVN R3 = ~(0x00FF << 1); rn deliberately nonzero to spot LOADA
        preload(3'd1, 16'h00FF);
        exp_q.push_back('{wn: 3'd3, d: 16'hFE01});
        run_op(2'b11, 2'b01, 3'd6, 3'd1, 3'd3, lat, wr, rf1);
        check("mvn_latency", lat, 4);
        check("mvn_no_loada", {29'd0, rf1}, 32'd1);
        check("mvn_writes", wr, 1);
        @(posedge clk); #1;
        check("mvn_r3", {16'd0, rf[3]}, 32'hFE01);
        check("mvn_status_kept", {29'd0, status}, 32'b001);

        // ADD with ASR1 and LSR1 shifts
        preload(3'd0, 16'h0000);
        preload(3'd1, 16'h8002);
        exp_q.push_back('{wn: 3'd4, d: 16'hC001});
        run_op(2'b00, 2'b11, 3'd0, 3'd1, 3'd4, lat, wr, rf1);
        @(posedge clk); #1;
        check("asr_r4", {16'd0, rf[4]}, 32'hC001);
        exp_q.push_back('{wn: 3'd4, d: 16'h4001});
        run_op(2'b00, 2'b10, 3'd0, 3'd1, 3'd4, lat, wr, rf1);
        @(posedge clk); #1;
        check("lsr_r4", {16'd0, rf[4]}, 32'h4001);

        // AND 0x0F0F & (0x00FF << 1)
        preload(3'd0, 16'h0F0F);
        preload(3'd1, 16'h00FF);
        exp_q.push_back('{wn: 3'd5, d: 16'h010E});
        run_op(2'b10, 2'b01, 3'd0, 3'd1, 3'd5, lat, wr, rf1);
        check("and_latency", lat, 5);
        @(posedge clk); #1;
        check("and_r5", {16'd0, rf[5]}, 32'h010E);

        // Reset during EXEC of an ADD: no write, destination unchanged
        preload(3'd0, 16'h0005);
        preload(3'd1, 16'h0003);
        preload(3'd6, 16'h1234);
        wr = wr_cnt;
        start = 1'b1; op = 2'b00; shift = 2'b00; rn = 3'd0; rm = 3'd1; rd = 3'd6;
        @(posedge clk); #1; start = 1'b0;   // LOADA
        @(posedge clk); #1;                 // LOADB
        @(posedge clk); #1;                 // EXEC
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rexec_busy", {31'd0, busy}, 32'd0);
        check("rexec_write", {31'd0, write}, 32'd0);
        check("rexec_writenum", {29'd0, writenum}, 32'd0);
        check("rexec_data_in", {16'd0, data_in}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("rexec_r6", {16'd0, rf[6]}, 32'h1234);
        check("rexec_writes", wr_cnt - wr, 0);
        $display("reset-in-EXEC: busy=%0d r6=%h", busy, rf[6]);

        // Start pulses mid-operation and during DONE are ignored
        preload(3'd7, 16'h7777);
        exp_q.push_back('{wn: 3'd2, d: 16'h0008});
        wr = wr_cnt;
        start = 1'b1; op = 2'b00; shift = 2'b00; rn = 3'd0; rm = 3'd1; rd = 3'd2;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; op = 2'b11; rd = 3'd7;
        @(posedge clk); #1; start = 1'b0;
        lat = 3;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("mid_latency", lat, 5);
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        check("done_start_ignored", {31'd0, busy}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("mid_writes", wr_cnt - wr, 1);
        check("mid_r7", {16'd0, rf[7]}, 32'h7777);
        check("mid_r2", {16'd0, rf[2]}, 32'h0008);
        $display("mid-op start: writes=%0d r7=%h", wr_cnt - wr, rf[7]);

        check("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
